iob_cache_axi_read_arbiter: RTL and testbench
=============================================

# iob_cache_axi_read_arbiter

Round-robin arbiter that shares one AXI4 read port (AR + R channels) among `N_MASTERS` cache back-end read FSMs, e.g. several cache instances or an instruction/data cache pair. It sits between the caches' `axi_ar*`/`axi_r*` ports and the system interconnect. It grants one requester per burst and holds the grant from AR acceptance until the final R beat (`rlast`) completes. Only one burst is ever outstanding on the shared port.

## Interface
- `N_MASTERS`, 2: number of requesting read channels (≥2).
- `AXI_ID_W`, 1: ID width, passed through unchanged.
- `AXI_ADDR_W`, 32: address width.
- `AXI_DATA_W`, 32: data width.
- `AXI_LEN_W`, 8: burst-length width.
- `clk_i`  in  1  system clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `s_axi_arvalid_i`  in  N_MASTERS  per-requester AR valid.
- `s_axi_arready_o`  out  N_MASTERS  per-requester AR ready.
- `s_axi_arid_i`, `s_axi_araddr_i`, `s_axi_arlen_i`, `s_axi_arsize_i`, `s_axi_arburst_i`, `s_axi_arlock_i`, `s_axi_arcache_i`, `s_axi_arprot_i`, `s_axi_arqos_i`  in  N_MASTERS×field width (ID_W, ADDR_W, LEN_W, 3, 2, 1, 4, 3, 4)  flattened AR fields; requester i occupies slice i.
- `s_axi_rvalid_o`  out  N_MASTERS  per-requester R valid.
- `s_axi_rready_i`  in  N_MASTERS  per-requester R ready.
- `s_axi_rid_o`, `s_axi_rdata_o`, `s_axi_rresp_o`, `s_axi_rlast_o`  out  ID_W, DATA_W, 2, 1  R payload broadcast to all requesters.
- `m_axi_ar*_o` / `m_axi_arready_i`  out/in  single-field widths  shared AR master channel.
- `m_axi_r*_i` / `m_axi_rready_o`  in/out  single-field widths  shared R master channel.
- `grant_o`  out  $clog2(N_MASTERS)  index of the current owner; valid when `busy_o` is high.
- `busy_o`  out  1  high in ADDR and DATA states.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any `s_axi_arvalid_i` bit is set, select the first set bit at or after `rr_ptr`, searching upward with wrap-around.
  - Register that index into `grant`; go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - `m_axi_arvalid_o` = `s_axi_arvalid_i[grant]`; all `m_axi_ar*` fields are muxed from slice `grant`.
  - `s_axi_arready_o[grant]` = `m_axi_arready_i`; all other `s_axi_arready_o` bits are 0.
  - Go to DATA on the AR handshake.
- DATA:
  - `s_axi_rvalid_o[grant]` = `m_axi_rvalid_i`; all other bits are 0.
  - `m_axi_rready_o` = `s_axi_rready_i[grant]`.
  - On an R handshake with `m_axi_rlast_i`=1: set `rr_ptr` = (`grant`+1) mod `N_MASTERS`, then go to IDLE.
- Outside ADDR, `m_axi_arvalid_o` = 0 and `s_axi_arready_o` = 0. Outside DATA, `s_axi_rvalid_o` = 0 and `m_axi_rready_o` = 0.
- R payload (`rid`, `rdata`, `rresp`, `rlast`) is broadcast unconditionally; only valid is gated.
- `rresp` errors pass through; the arbiter takes no action on them.
- Once a grant is issued it is never revoked. Requesters must hold `arvalid` per AXI rules.
- R beats arriving in IDLE or ADDR are not accepted (`m_axi_rready_o`=0).

## Timing
- Reset values (asynchronous):
  - state = IDLE, `rr_ptr` = 0, `grant` = 0.
  - `busy_o` = 0, `m_axi_arvalid_o` = 0, `m_axi_rready_o` = 0.
  - `s_axi_arready_o` = 0, `s_axi_rvalid_o` = 0.
- Arbitration latency: request sampled in IDLE at edge k; `m_axi_arvalid_o` is high in cycle k+1. The combinational AR/R paths add no further latency.
- Back-to-back: an `rlast` handshake at edge t returns to IDLE in cycle t+1. The next grant's `arvalid` is high in cycle t+2, giving one idle cycle between bursts.
- Simultaneous requests are resolved by `rr_ptr`.
  - With requesters 0 and 1 held continuously, grants alternate 0,1,0,1.
  - A requester that is not requesting is skipped without costing a cycle.
- Wrap-around: with `rr_ptr` = N_MASTERS-1 and only requester 0 pending, requester 0 is granted.
- Single-beat burst (`arlen`=0): the first R handshake carries `rlast` and ends DATA.
- Reset asserted mid-ADDR or mid-DATA: outputs return to their reset values immediately, without waiting for a clock edge. The bus side must be reset together with the arbiter.

## Test plan
- Single request: requester 1 issues `araddr`=0x100, `arlen`=3.
  - Expect `m_axi_araddr_o`=0x100 one cycle later and `grant_o`=1.
  - Expect 4 beats on `s_axi_rvalid_o[1]` only, then `busy_o`=0.
- Simultaneous 0 and 1 from reset:
  - Expect requester 0 served first, requester 1 second.
  - Expect `rr_ptr` to end at 0 (with N=2).
- Three persistent requesters (N=3): over 6 bursts expect grant order 0,1,2,0,1,2.
- AR backpressure: hold `m_axi_arready_i`=0 for 5 cycles.
  - Expect `m_axi_arvalid_o` high and the address stable throughout.
  - Expect `s_axi_arready_o[grant]` to pulse only when ready rises.
- R backpressure: the granted requester drops `rready` for 3 cycles mid-burst.
  - Expect `m_axi_rready_o`=0 during those cycles and no beat lost.
  - Expect `rlast` seen exactly once.
- Reset in DATA after 2 of 4 beats:
  - Expect all valid/ready outputs 0 immediately.
  - After release, a new request from requester 0 is granted in 1 cycle.

Source files
------------

// File: rtl/iob_cache_axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port (AR + R) among several cache read FSMs.
// One burst is outstanding at a time. The grant is held from AR issue until the rlast beat.
module iob_cache_axi_read_arbiter #(
  parameter int unsigned N_MASTERS  = 2,
  parameter int unsigned AXI_ID_W   = 1,
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned AXI_LEN_W  = 8,
  localparam int unsigned GRANT_W   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  // requester AR channels, slice i belongs to requester i
  input  logic [N_MASTERS-1:0]             s_axi_arvalid_i,
  output logic [N_MASTERS-1:0]             s_axi_arready_o,
  input  logic [N_MASTERS*AXI_ID_W-1:0]    s_axi_arid_i,
  input  logic [N_MASTERS*AXI_ADDR_W-1:0]  s_axi_araddr_i,
  input  logic [N_MASTERS*AXI_LEN_W-1:0]   s_axi_arlen_i,
  input  logic [N_MASTERS*3-1:0]           s_axi_arsize_i,
  input  logic [N_MASTERS*2-1:0]           s_axi_arburst_i,
  input  logic [N_MASTERS-1:0]             s_axi_arlock_i,
  input  logic [N_MASTERS*4-1:0]           s_axi_arcache_i,
  input  logic [N_MASTERS*3-1:0]           s_axi_arprot_i,
  input  logic [N_MASTERS*4-1:0]           s_axi_arqos_i,
  // requester R channels, payload broadcast
  output logic [N_MASTERS-1:0]             s_axi_rvalid_o,
  input  logic [N_MASTERS-1:0]             s_axi_rready_i,
  output logic [AXI_ID_W-1:0]              s_axi_rid_o,
  output logic [AXI_DATA_W-1:0]            s_axi_rdata_o,
  output logic [1:0]                       s_axi_rresp_o,
  output logic                             s_axi_rlast_o,
  // shared AR master channel
  output logic                             m_axi_arvalid_o,
  input  logic                             m_axi_arready_i,
  output logic [AXI_ID_W-1:0]              m_axi_arid_o,
  output logic [AXI_ADDR_W-1:0]            m_axi_araddr_o,
  output logic [AXI_LEN_W-1:0]             m_axi_arlen_o,
  output logic [2:0]                       m_axi_arsize_o,
  output logic [1:0]                       m_axi_arburst_o,
  output logic                             m_axi_arlock_o,
  output logic [3:0]                       m_axi_arcache_o,
  output logic [2:0]                       m_axi_arprot_o,
  output logic [3:0]                       m_axi_arqos_o,
  // shared R master channel
  input  logic                             m_axi_rvalid_i,
  output logic                             m_axi_rready_o,
  input  logic [AXI_ID_W-1:0]              m_axi_rid_i,
  input  logic [AXI_DATA_W-1:0]            m_axi_rdata_i,
  input  logic [1:0]                       m_axi_rresp_i,
  input  logic                             m_axi_rlast_i,
  // status
  output logic [GRANT_W-1:0]               grant_o,
  output logic                             busy_o
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e               state_q;
  logic [GRANT_W-1:0]   grant_q;
  logic [GRANT_W-1:0]   rr_ptr_q;
  logic                 busy_q;

  logic [GRANT_W-1:0]   pick;
  logic                 any_req;
  logic [GRANT_W:0]     cand;
  logic [GRANT_W-1:0]   rr_next;
  logic                 rlast_hs;

  // First pending requester at or after rr_ptr, searching upward with wrap-around
  always_comb begin
    pick    = rr_ptr_q;
    any_req = 1'b0;
    cand    = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      cand = {1'b0, rr_ptr_q} + (GRANT_W + 1)'(i);
      if (cand >= (GRANT_W + 1)'(N_MASTERS)) begin
        cand = cand - (GRANT_W + 1)'(N_MASTERS);
      end
      if (!any_req && s_axi_arvalid_i[cand[GRANT_W-1:0]]) begin
        pick    = cand[GRANT_W-1:0];
        any_req = 1'b1;
      end
    end
  end

  assign rr_next  = (grant_q == GRANT_W'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;
  assign rlast_hs = m_axi_rvalid_i && m_axi_rready_o && m_axi_rlast_i;

  // Arbitration FSM; grant, pointer and busy are registered here
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_q <= pick;
            busy_q  <= 1'b1;
            state_q <= StAddr;
          end
        end
        StAddr: begin
          if (m_axi_arvalid_o && m_axi_arready_i) begin
            state_q <= StData;
          end
        end
        StData: begin
          if (rlast_hs) begin
            rr_ptr_q <= rr_next;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Steer AR fields and handshakes to/from the granted slice; gate by state
  always_comb begin
    m_axi_arvalid_o = 1'b0;
    m_axi_arid_o    = '0;
    m_axi_araddr_o  = '0;
    m_axi_arlen_o   = '0;
    m_axi_arsize_o  = '0;
    m_axi_arburst_o = '0;
    m_axi_arlock_o  = 1'b0;
    m_axi_arcache_o = '0;
    m_axi_arprot_o  = '0;
    m_axi_arqos_o   = '0;
    m_axi_rready_o  = 1'b0;
    s_axi_arready_o = '0;
    s_axi_rvalid_o  = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        m_axi_arid_o    = s_axi_arid_i[i*AXI_ID_W +: AXI_ID_W];
        m_axi_araddr_o  = s_axi_araddr_i[i*AXI_ADDR_W +: AXI_ADDR_W];
        m_axi_arlen_o   = s_axi_arlen_i[i*AXI_LEN_W +: AXI_LEN_W];
        m_axi_arsize_o  = s_axi_arsize_i[i*3 +: 3];
        m_axi_arburst_o = s_axi_arburst_i[i*2 +: 2];
        m_axi_arlock_o  = s_axi_arlock_i[i];
        m_axi_arcache_o = s_axi_arcache_i[i*4 +: 4];
        m_axi_arprot_o  = s_axi_arprot_i[i*3 +: 3];
        m_axi_arqos_o   = s_axi_arqos_i[i*4 +: 4];
        if (state_q == StAddr) begin
          m_axi_arvalid_o    = s_axi_arvalid_i[i];
          s_axi_arready_o[i] = m_axi_arready_i;
        end
        if (state_q == StData) begin
          s_axi_rvalid_o[i] = m_axi_rvalid_i;
          m_axi_rready_o    = s_axi_rready_i[i];
        end
      end
    end
  end

  // R payload is broadcast; only valid is steered
  assign s_axi_rid_o   = m_axi_rid_i;
  assign s_axi_rdata_o = m_axi_rdata_i;
  assign s_axi_rresp_o = m_axi_rresp_i;
  assign s_axi_rlast_o = m_axi_rlast_i;

  assign grant_o = grant_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_iob_cache_axi_read_arbiter.sv
// Directed bench for iob_cache_axi_read_arbiter with three requesters.
module tb_iob_cache_axi_read_arbiter;

  localparam int N = 3;

  logic         clk, rst;
  logic [2:0]   s_arvalid, s_arready, s_rvalid, s_rready;
  logic [5:0]   s_arid;
  logic [95:0]  s_araddr;
  logic [23:0]  s_arlen;
  logic [8:0]   s_arsize;
  logic [5:0]   s_arburst;
  logic [2:0]   s_arlock;
  logic [11:0]  s_arcache;
  logic [8:0]   s_arprot;
  logic [11:0]  s_arqos;
  logic [1:0]   s_rid;
  logic [31:0]  s_rdata;
  logic [1:0]   s_rresp;
  logic         s_rlast;
  logic         m_arvalid, m_arready;
  logic [1:0]   m_arid;
  logic [31:0]  m_araddr;
  logic [7:0]   m_arlen;
  logic [2:0]   m_arsize;
  logic [1:0]   m_arburst;
  logic         m_arlock;
  logic [3:0]   m_arcache;
  logic [2:0]   m_arprot;
  logic [3:0]   m_arqos;
  logic         m_rvalid, m_rready;
  logic [1:0]   m_rid;
  logic [31:0]  m_rdata;
  logic [1:0]   m_rresp;
  logic         m_rlast;
  logic [1:0]   grant;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  iob_cache_axi_read_arbiter #(
    .N_MASTERS(N), .AXI_ID_W(2), .AXI_ADDR_W(32), .AXI_DATA_W(32), .AXI_LEN_W(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_axi_arvalid_i(s_arvalid), .s_axi_arready_o(s_arready), .s_axi_arid_i(s_arid),
    .s_axi_araddr_i(s_araddr), .s_axi_arlen_i(s_arlen), .s_axi_arsize_i(s_arsize),
    .s_axi_arburst_i(s_arburst), .s_axi_arlock_i(s_arlock), .s_axi_arcache_i(s_arcache),
    .s_axi_arprot_i(s_arprot), .s_axi_arqos_i(s_arqos),
    .s_axi_rvalid_o(s_rvalid), .s_axi_rready_i(s_rready), .s_axi_rid_o(s_rid),
    .s_axi_rdata_o(s_rdata), .s_axi_rresp_o(s_rresp), .s_axi_rlast_o(s_rlast),
    .m_axi_arvalid_o(m_arvalid), .m_axi_arready_i(m_arready), .m_axi_arid_o(m_arid),
    .m_axi_araddr_o(m_araddr), .m_axi_arlen_o(m_arlen), .m_axi_arsize_o(m_arsize),
    .m_axi_arburst_o(m_arburst), .m_axi_arlock_o(m_arlock), .m_axi_arcache_o(m_arcache),
    .m_axi_arprot_o(m_arprot), .m_axi_arqos_o(m_arqos),
    .m_axi_rvalid_i(m_rvalid), .m_axi_rready_o(m_rready), .m_axi_rid_i(m_rid),
    .m_axi_rdata_i(m_rdata), .m_axi_rresp_i(m_rresp), .m_axi_rlast_i(m_rlast),
    .grant_o(grant), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled just after the falling edge
  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_arvalid"}, m_arvalid, 0);
    check({tag, "_rready"}, m_rready, 0);
    check({tag, "_s_arready"}, s_arready, 0);
    check({tag, "_s_rvalid"}, s_rvalid, 0);
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    #1;
    check_quiet("rst");
    check("rst_grant", grant, 0);
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Serve one burst from requester g; caller has already raised its arvalid while idle.
  task automatic serve(input int g, input logic [31:0] addr, input int len, input int ar_stall,
                       input int r_stall_beat, input bit keep);
    int n;
    int lasts;
    s_araddr[g*32 +: 32] = addr;
    s_arlen[g*8 +: 8]    = 8'(len);
    n = 0;
    #1;
    while (!busy && n < 8) begin
      n++;
      tick;
    end
    check("idle_cycles", n, 1);
    check("grant", grant, g);
    check("m_arvalid", m_arvalid, 1);
    check("m_araddr", m_araddr, addr);
    check("m_arlen", m_arlen, len);
    check("m_arid", m_arid, g);
    check("m_arprot", m_arprot, g);
    check("m_arqos", m_arqos, g + 4);
    for (int k = 0; k < ar_stall; k++) begin
      m_arready = 1'b0;
      #1;
      check("ar_stall_s_arready", s_arready, 0);
      check("ar_stall_arvalid", m_arvalid, 1);
      check("ar_stall_addr", m_araddr, addr);
      tick;
    end
    m_arready = 1'b1;
    #1;
    check("s_arready_pulse", s_arready, 64'(1) << g);
    tick;
    m_arready = 1'b0;
    if (!keep) s_arvalid[g] = 1'b0;
    lasts = 0;
    for (int b = 0; b <= len; b++) begin
      m_rvalid = 1'b1;
      m_rdata  = addr + 32'(b);
      m_rid    = 2'(g);
      m_rlast  = (b == len);
      m_rresp  = (b == 1) ? 2'b10 : 2'b00;
      if (b == r_stall_beat) begin
        for (int k = 0; k < 3; k++) begin
          s_rready[g] = 1'b0;
          #1;
          check("r_stall_m_rready", m_rready, 0);
          tick;
        end
        s_rready[g] = 1'b1;
      end
      #1;
      check("data_arvalid", m_arvalid, 0);
      check("s_rvalid", s_rvalid, 64'(1) << g);
      check("m_rready", m_rready, 1);
      check("s_rdata", s_rdata, addr + 32'(b));
      check("s_rresp", s_rresp, (b == 1) ? 2 : 0);
      check("s_rid", s_rid, g);
      if (s_rvalid[g] && s_rready[g] && s_rlast) lasts++;
      tick;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    check("after_busy", busy, 0);
    check("after_s_rvalid", s_rvalid, 0);
    check("rlast_count", lasts, 1);
  endtask

  initial begin
    rst       = 1'b1;
    s_arvalid = '0;
    s_rready  = 3'b111;
    s_araddr  = '0;
    s_arlen   = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rid     = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rlast   = 1'b0;
    for (int i = 0; i < N; i++) begin
      s_arid[i*2 +: 2]    = 2'(i);
      s_arsize[i*3 +: 3]  = 3'd2;
      s_arburst[i*2 +: 2] = 2'd1;
      s_arlock[i]         = 1'b0;
      s_arcache[i*4 +: 4] = 4'h3;
      s_arprot[i*3 +: 3]  = 3'(i);
      s_arqos[i*4 +: 4]   = 4'(i + 4);
    end

    // Reset state
    pulse_reset();
    tick;
    check_quiet("idle");

    // Single request from requester 1 (pointer at 0, so requester 0 is skipped)
    s_arvalid = 3'b010;
    serve(1, 32'h100, 3, 0, -1, 1'b0);

    // Pointer now 2; only requester 0 pending -> wrap-around grant
    s_arvalid = 3'b001;
    serve(0, 32'h40, 0, 0, -1, 1'b0);

    // Reset in DATA after 2 of 4 beats
    s_arvalid = 3'b100;
    s_araddr[64 +: 32] = 32'h300;
    s_arlen[16 +: 8]   = 8'd3;
    tick;
    check("rstdata_grant", grant, 2);
    m_arready = 1'b1;
    tick;
    m_arready = 1'b0;
    s_arvalid = '0;
    m_rvalid  = 1'b1;
    m_rdata   = 32'h300;
    tick;
    m_rdata   = 32'h301;
    tick;
    m_rdata   = 32'h302;
    #1;
    check("rstdata_in_data", s_rvalid, 3'b100);
    rst = 1'b1;
    #1;
    check_quiet("rst_mid_data");
    check("rst_mid_data_grant", grant, 0);
    m_rvalid = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    s_arvalid = 3'b001;
    serve(0, 32'h500, 1, 0, -1, 1'b0);

    // Simultaneous 0 and 1 from reset
    pulse_reset();
    tick;
    s_arvalid = 3'b011;
    serve(0, 32'h1000, 1, 0, -1, 1'b0);
    serve(1, 32'h2000, 2, 0, -1, 1'b0);

    // Three persistent requesters, with AR and R backpressure mixed in
    pulse_reset();
    tick;
    s_arvalid = 3'b111;
    serve(0, 32'h4000, 1, 0, -1, 1'b1);
    serve(1, 32'h5000, 2, 5, -1, 1'b1);
    serve(2, 32'h6000, 0, 0, -1, 1'b1);
    serve(0, 32'h7000, 3, 0,  1, 1'b1);
    serve(1, 32'h8000, 1, 0, -1, 1'b1);
    serve(2, 32'h9000, 1, 0, -1, 1'b1);
    s_arvalid = '0;
    tick;
    tick;
    check_quiet("end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
